// File: rtl/spi_ram_ctrl_if.sv
// Frame/response bus between the SPI slave and the command-decoding RAM.
// The master side drives frames; the slave side returns read data and status.
interface spi_ram_ctrl_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;
    logic       wr_addr_vld;
    logic       rd_addr_vld;

    modport master (
        output din, rx_valid,
        input  dout, tx_valid, cmd_err, wr_addr_vld, rd_addr_vld
    );

    modport slave (
        input  din, rx_valid,
        output dout, tx_valid, cmd_err, wr_addr_vld, rd_addr_vld
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind an SPI slave: 10-bit frames carry
// a 2-bit opcode and 8-bit payload; reads return one cycle after the frame.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    // Addresses wider than the array fold back onto it modulo MEM_DEPTH.
    function automatic idx_t to_idx(input logic [ADDR_SIZE-1:0] a);
        return idx_t'(32'(a) % 32'(MEM_DEPTH));
    endfunction

    function automatic idx_t wrap_inc(input idx_t i);
        return (i == idx_t'(MEM_DEPTH - 1)) ? '0 : i + 1'b1;
    endfunction

    logic [7:0] mem [MEM_DEPTH];

    opcode_e    op;
    logic [7:0] payload;
    idx_t       frame_idx;
    logic       do_wr_addr, do_wr_data, do_rd_addr, do_rd_data, seq_err;

    idx_t       wr_addr, rd_addr;
    logic       wr_addr_vld, rd_addr_vld;
    logic [7:0] dout;
    logic       tx_valid, cmd_err;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        op         = opcode_e'(bus.din[9:8]);
        payload    = bus.din[7:0];
        frame_idx  = to_idx(payload[ADDR_SIZE-1:0]);
        do_wr_addr = 1'b0;
        do_wr_data = 1'b0;
        do_rd_addr = 1'b0;
        do_rd_data = 1'b0;
        seq_err    = 1'b0;
        if (bus.rx_valid) begin
            unique case (op)
                OP_WR_ADDR: do_wr_addr = 1'b1;
                OP_WR_DATA: if (wr_addr_vld) do_wr_data = 1'b1; else seq_err = 1'b1;
                OP_RD_ADDR: do_rd_addr = 1'b1;
                OP_RD_DATA: if (rd_addr_vld) do_rd_data = 1'b1; else seq_err = 1'b1;
            endcase
        end
    end

    // NOTE: the storage array has no reset branch; clearing it would turn the
    // RAM into a huge flop bank. Only control state is reset.
    always_ff @(posedge clk) begin
        if (!rst && do_wr_data) mem[wr_addr] <= payload;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout        <= '0;
            tx_valid    <= 1'b0;
            cmd_err     <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_addr_vld <= 1'b0;
            rd_addr_vld <= 1'b0;
        end else begin
            tx_valid <= do_rd_data;
            cmd_err  <= seq_err;
            if (do_rd_data) dout <= mem[rd_addr];

            if (do_wr_addr) begin
                wr_addr     <= frame_idx;
                wr_addr_vld <= 1'b1;
            end else if (do_wr_data && AUTO_INC) begin
                wr_addr <= wrap_inc(wr_addr);
            end

            if (do_rd_addr) begin
                rd_addr     <= frame_idx;
                rd_addr_vld <= 1'b1;
            end else if (do_rd_data && AUTO_INC) begin
                rd_addr <= wrap_inc(rd_addr);
            end
        end
    end

    assign bus.dout        = dout;
    assign bus.tx_valid    = tx_valid;
    assign bus.cmd_err     = cmd_err;
    assign bus.wr_addr_vld = wr_addr_vld;
    assign bus.rd_addr_vld = rd_addr_vld;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench: three parameterisations share one frame stream; a
// behavioural model queues expected outputs that are compared after each edge.
module tb_spi_ram_ctrl;

    logic       clk, rst, rx_valid;
    logic [9:0] din;

    spi_ram_ctrl_if b0 ();
    spi_ram_ctrl_if b1 ();
    spi_ram_ctrl_if b2 ();

    assign b0.din = din;  assign b0.rx_valid = rx_valid;
    assign b1.din = din;  assign b1.rx_valid = rx_valid;
    assign b2.din = din;  assign b2.rx_valid = rx_valid;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    spi_ram_ctrl #(.MEM_DEPTH(16),  .ADDR_SIZE(8), .AUTO_INC(1'b1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    // {dout, tx_valid, cmd_err, wr_addr_vld, rd_addr_vld} per instance
    logic [11:0] obs [3];
    assign obs[0] = {b0.dout, b0.tx_valid, b0.cmd_err, b0.wr_addr_vld, b0.rd_addr_vld};
    assign obs[1] = {b1.dout, b1.tx_valid, b1.cmd_err, b1.wr_addr_vld, b1.rd_addr_vld};
    assign obs[2] = {b2.dout, b2.tx_valid, b2.cmd_err, b2.wr_addr_vld, b2.rd_addr_vld};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         inst;
        logic [7:0] dout;
        logic       tx;
        logic       err;
        logic       wv;
        logic       rv;
    } exp_t;

    exp_t sb_q [$];

    int         n_checks = 0;
    int         n_fail   = 0;

    int         depth [3] = '{256, 256, 16};
    bit         ainc  [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] m_mem [3][256];
    int         m_wa  [3];
    int         m_ra  [3];
    bit         m_wv  [3];
    bit         m_rv  [3];
    logic [7:0] m_dout[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [9:0] f);
        exp_t e;
        @(negedge clk);
        rst = r; rx_valid = v; din = f;
        for (int i = 0; i < 3; i++) begin
            e.tx = 1'b0;
            e.err = 1'b0;
            if (r) begin
                m_wa[i] = 0; m_ra[i] = 0; m_wv[i] = 1'b0; m_rv[i] = 1'b0; m_dout[i] = 8'h00;
            end else if (v) begin
                case (f[9:8])
                    2'b00: begin m_wa[i] = int'(f[7:0]) % depth[i]; m_wv[i] = 1'b1; end
                    2'b01: if (m_wv[i]) begin
                               m_mem[i][m_wa[i]] = f[7:0];
                               if (ainc[i]) m_wa[i] = (m_wa[i] + 1) % depth[i];
                           end else e.err = 1'b1;
                    2'b10: begin m_ra[i] = int'(f[7:0]) % depth[i]; m_rv[i] = 1'b1; end
                    default: if (m_rv[i]) begin
                               m_dout[i] = m_mem[i][m_ra[i]];
                               e.tx = 1'b1;
                               if (ainc[i]) m_ra[i] = (m_ra[i] + 1) % depth[i];
                           end else e.err = 1'b1;
                endcase
            end
            e.inst = i; e.dout = m_dout[i]; e.wv = m_wv[i]; e.rv = m_rv[i];
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("u%0d.dout", e.inst),        32'(obs[e.inst][11:4]), 32'(e.dout));
            check($sformatf("u%0d.tx_valid", e.inst),    32'(obs[e.inst][3]),    32'(e.tx));
            check($sformatf("u%0d.cmd_err", e.inst),     32'(obs[e.inst][2]),    32'(e.err));
            check($sformatf("u%0d.wr_addr_vld", e.inst), 32'(obs[e.inst][1]),    32'(e.wv));
            check($sformatf("u%0d.rd_addr_vld", e.inst), 32'(obs[e.inst][0]),    32'(e.rv));
        end
    endtask

    task automatic frame(input logic [1:0] op, input logic [7:0] pl);
        step(1'b0, 1'b1, {op, pl});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 10'h3EE);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; din = '0;

        // reset, then seed mem[0] and reset again: contents must survive
        step(1'b1, 1'b0, 10'h0); step(1'b1, 1'b0, 10'h0); idle();
        frame(2'b00, 8'h00); frame(2'b01, 8'h66); idle();
        step(1'b1, 1'b0, 10'h0); step(1'b1, 1'b0, 10'h0); idle();

        // out-of-sequence commands after reset
        frame(2'b01, 8'h33); idle();
        frame(2'b11, 8'h00); idle();
        frame(2'b10, 8'h00); frame(2'b11, 8'h00); idle();

        // basic write/read with gaps
        frame(2'b00, 8'h12); idle(); frame(2'b01, 8'hA5); idle();
        frame(2'b10, 8'h12); idle(); frame(2'b11, 8'h00); idle(); idle();

        // address wrap at the top of memory
        frame(2'b00, 8'hFF); frame(2'b01, 8'h11); frame(2'b01, 8'h22); idle();
        frame(2'b10, 8'hFF); frame(2'b11, 8'h00); idle(); frame(2'b11, 8'h00); idle();

        // back-to-back frames
        frame(2'b00, 8'h05); frame(2'b01, 8'h5A); frame(2'b10, 8'h05); frame(2'b11, 8'h00);
        idle(); idle();

        // last read address wins, dout holds, rx_valid=0 frames are ignored
        frame(2'b10, 8'h12); frame(2'b10, 8'h05); frame(2'b11, 8'h00);
        step(1'b0, 1'b0, {2'b11, 8'h00}); idle();

        // reset beats a read in the same cycle; flags stay cleared
        step(1'b1, 1'b1, {2'b11, 8'h00}); idle();
        frame(2'b11, 8'h00); idle();
        frame(2'b01, 8'h44); idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
